// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame-state encoding and scan-code prefix constants for the PS/2 receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;
    localparam logic [7:0] SC_EXTENDED = 8'hE0;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchroniser for an asynchronous pin plus falling-edge detect.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);
    logic meta_q, sync_q, prev_q;
    always_ff @(posedge clock) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end
    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 frame receiver that folds E0/F0 prefixes into one key event per scan code.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter bit FILTER_BREAK   = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out,
    output logic       ps2_extended,
    output logic       ps2_break,
    output logic       ps2_frame_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    logic fall, data, unused_sync;
    logic clk_level, data_fall;
    frame_state_e state_q;
    logic [2:0] idx_q;
    logic [7:0] shift_q, byte_q;
    logic par_q, good_q, ext_q, brk_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic frame_ok_d;

    ps2_sync_edge u_clk (.clock(clock), .reset(reset), .pin_i(ps2_clock_in), .level_o(clk_level), .fall_o(fall));
    ps2_sync_edge u_dat (.clock(clock), .reset(reset), .pin_i(ps2_data_in), .level_o(data), .fall_o(data_fall));
    assign unused_sync = clk_level ^ data_fall;

    // Counter saturates at TMO so a stalled frame never wraps back past the abort point.
    assign cnt_d      = (state_q == IDLE || fall) ? '0 : (cnt_q == TMO) ? cnt_q : cnt_q + CW'(1);
    assign frame_ok_d = data && (^{shift_q, par_q});

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            shift_q         <= '0;
            par_q           <= 1'b0;
            cnt_q           <= '0;
            byte_q          <= '0;
            good_q          <= 1'b0;
            ext_q           <= 1'b0;
            brk_q           <= 1'b0;
            ps2_key_pressed <= 1'b0;
            ps2_out         <= '0;
            ps2_extended    <= 1'b0;
            ps2_break       <= 1'b0;
            ps2_frame_err   <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            good_q          <= 1'b0;
            ps2_key_pressed <= 1'b0;
            ps2_frame_err   <= 1'b0;
            if (good_q) begin
                if (byte_q == SC_EXTENDED)
                    ext_q <= 1'b1;
                else if (byte_q == SC_BREAK)
                    brk_q <= 1'b1;
                else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (!(brk_q && FILTER_BREAK)) begin
                        ps2_key_pressed <= 1'b1;
                        ps2_out         <= byte_q;
                        ps2_extended    <= ext_q;
                        ps2_break       <= brk_q;
                    end
                end
            end
            if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!data) state_q <= DATA;
                        idx_q <= '0;
                    end
                    DATA: begin
                        shift_q[idx_q] <= data;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= data;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        byte_q  <= shift_q;
                        if (frame_ok_d)
                            good_q <= 1'b1;
                        else begin
                            ps2_frame_err <= 1'b1;
                            ext_q         <= 1'b0;
                            brk_q         <= 1'b0;
                        end
                    end
                endcase
            end else if (state_q != IDLE && cnt_q == TMO) begin
                state_q       <= IDLE;
                ps2_frame_err <= 1'b1;
                ext_q         <= 1'b0;
                brk_q         <= 1'b0;
            end
        end
    end
endmodule
